// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared FSM encoding, port IDs and defaults for the ALU control path
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int DEFAULT_WAIT_LIMIT = 4;

endpackage

// File: rtl/alu_op_arbiter_if.sv
// rtl/alu_op_arbiter_if.sv - requester, ALU and response signals of the ALU op arbiter
interface alu_op_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FUN_WIDTH  = 4
);
  logic                  req0_valid, req1_valid;
  logic [DATA_WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [FUN_WIDTH-1:0]  req0_fun, req1_fun;
  logic                  req0_ready, req1_ready;
  logic [DATA_WIDTH-1:0] alu_a, alu_b;
  logic [FUN_WIDTH-1:0]  alu_fun;
  logic                  alu_en;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  alu_valid;
  logic                  rsp_valid;
  logic                  rsp_id;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_fun, req1_fun,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_fun, alu_en,
    output alu_out, alu_valid,
    input  rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_fun, req1_fun,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_fun, alu_en,
    input  alu_out, alu_valid,
    output rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - two-requester grant with last-grant pointer
// ALU_OP_ARBITER_RR_EN selects round-robin; otherwise fixed priority to port 0.
module alu_rr_arbiter
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       arb_en,
  input  logic [1:0] req_valid,
  output logic [1:0] grant
);
  logic favour1;

`ifdef ALU_OP_ARBITER_RR_EN
  logic last_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= PORT1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

  assign favour1 = (last_grant == PORT0);
`else
  logic unused_stub;

  assign unused_stub = clk ^ rst;
  assign favour1     = 1'b0;
`endif

  always_comb begin
    grant = 2'b00;
    if (arb_en) begin
      if (req_valid == 2'b11) begin
        grant = favour1 ? 2'b10 : 2'b01;
      end else begin
        grant = req_valid;
      end
    end
  end

endmodule

// File: rtl/alu_op_arbiter.sv
// rtl/alu_op_arbiter.sv - arbitrates two requesters onto a shared ALU and returns tagged results
// Arbitration policy is set by ALU_OP_ARBITER_RR_EN (see alu_rr_arbiter).
module alu_op_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FUN_WIDTH  = 4,
  parameter int WAIT_LIMIT = DEFAULT_WAIT_LIMIT
) (
  input logic             clk,
  input logic             rst,
  alu_op_arbiter_if.slave bus
);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_LIMIT - 1);

  state_t                state, state_nxt;
  logic [1:0]            req_valid, grant;
  logic                  arb_en, accept, grant_id, op_id, wait_done;
  logic [3:0]            wait_cnt;
  logic [DATA_WIDTH-1:0] a_q, b_q, rsp_data_q;
  logic [FUN_WIDTH-1:0]  fun_q;
  logic                  rsp_id_q, rsp_err_q, alu_en_c, rsp_valid_c;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign arb_en    = (state == IDLE) && !rst;

  alu_rr_arbiter u_arb (
    .clk      (clk),
    .rst      (rst),
    .arb_en   (arb_en),
    .req_valid(req_valid),
    .grant    (grant)
  );

  assign accept         = |grant;
  assign grant_id       = grant[1];
  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  // A late alu_valid on the final wait cycle still wins over the timeout.
  assign wait_done      = bus.alu_valid || (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (wait_done) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_en_c    = 1'b0;
    rsp_valid_c = 1'b0;
    case (state)
      ISSUE:   alu_en_c    = 1'b1;
      RESP:    rsp_valid_c = 1'b1;
      default: ;
    endcase
  end

  // Operands load on acceptance so they are already on the ALU bus in ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      fun_q      <= '0;
      op_id      <= PORT0;
      wait_cnt   <= '0;
      rsp_id_q   <= PORT0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= grant_id ? bus.req1_a   : bus.req0_a;
        b_q   <= grant_id ? bus.req1_b   : bus.req0_b;
        fun_q <= grant_id ? bus.req1_fun : bus.req0_fun;
        op_id <= grant_id;
      end
      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 4'd1;
        if (wait_done) begin
          rsp_id_q   <= op_id;
          rsp_data_q <= bus.alu_valid ? bus.alu_out : '0;
          rsp_err_q  <= !bus.alu_valid;
        end
      end
    end
  end

  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_fun   = fun_q;
  assign bus.alu_en    = alu_en_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
